// File: rtl/irq_sequencer_if.sv
// Bundle of the sequencer's core-side signals: IRQ pins, PC/ERET, cp0 write path, PC-mux controls.
// No latency of its own; pure wiring.
// No backpressure: every signal is a level or a single-cycle pulse.
interface irq_sequencer_if #(
  parameter int NUM_IRQ = 3
);
  // Inputs to the sequencer
  logic [NUM_IRQ-1:0] in_irq;
  logic [31:0]        in_pc;
  logic               in_eret;
  logic               in_cpw;
  logic [NUM_IRQ:0]   in_cpd;

  // Outputs from the sequencer
  logic               out_take;
  logic [31:0]        out_vector;
  logic               out_ret;
  logic [31:0]        out_epc;
  logic [NUM_IRQ-1:0] out_pend;
  logic [NUM_IRQ-1:0] out_insrv;
  logic               out_ie;

  // Core side: drives pins/PC/cp0, consumes redirect controls
  modport master (
    output in_irq, in_pc, in_eret, in_cpw, in_cpd,
    input  out_take, out_vector, out_ret, out_epc, out_pend, out_insrv, out_ie
  );

  // Sequencer side
  modport slave (
    input  in_irq, in_pc, in_eret, in_cpw, in_cpd,
    output out_take, out_vector, out_ret, out_epc, out_pend, out_insrv, out_ie
  );
endinterface

// File: rtl/irq_sequencer.sv
// Prioritised, optionally nested interrupt sequencer: edge-latches IRQs, redirects PC to vectors, stacks resume PCs.
// Latency: IRQ edge at cycle N -> pending at N+1 -> out_take at N+2; ERET in RUN -> out_ret next cycle.
// No backpressure; GUARD cycle after each take blocks new takes/ERETs. Macro IRQ_NEST_EN enables nesting.
module irq_sequencer #(
  parameter int          NUM_IRQ    = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_1000,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0100
) (
  input logic           in_clk,
  input logic           in_rst,
  irq_sequencer_if.slave bus
);

`ifdef IRQ_NEST_EN
  localparam int DEPTH = NUM_IRQ;
`else
  localparam int DEPTH = 1;
`endif
  localparam int IW  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int SPW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {RUN, TAKE, GUARD, RET} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] insrv;
  logic [NUM_IRQ-1:0] mask;
  logic               ie;
  logic [31:0]        stack [DEPTH];
  logic [SPW-1:0]     sp;
  logic [IW-1:0]      take_idx;
  logic               take;
  logic               ret;
  logic [31:0]        vector;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] elig;
  logic               any_elig;
  logic [IW-1:0]      win_idx;
  logic [NUM_IRQ-1:0] take_onehot;
  logic [NUM_IRQ-1:0] insrv_top;
  logic [31:0]        epc;

  assign rise        = bus.in_irq & ~prev;
  assign take_onehot = NUM_IRQ'(1) << take_idx;
  assign any_elig    = |elig;

  // Eligibility per line; when nesting, only lines above the highest in-service line may preempt
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
`ifdef IRQ_NEST_EN
      elig[i] = pend[i] & mask[i] & ie & ((insrv >> i) == '0);
`else
      elig[i] = pend[i] & mask[i] & ie;
`endif
    end
  end

  // Highest eligible index wins (later iterations override earlier ones)
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (elig[i]) win_idx = IW'(i);
    end
  end

  // One-hot of the highest in-service line, the one an ERET retires
  always_comb begin
    insrv_top = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (insrv[i]) begin
        insrv_top    = '0;
        insrv_top[i] = 1'b1;
      end
    end
  end

  // Top of the resume-PC stack; zero when empty
  always_comb begin
    epc = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sp == SPW'(k + 1)) epc = stack[k];
    end
  end

  // Previous IRQ sample; loads during reset too so a line held high through reset raises nothing
  always_ff @(posedge in_clk) begin
    prev <= bus.in_irq;
  end

  // Sequencer FSM with pending, in-service, cp0 and stack state and registered pulse outputs
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state    <= RUN;
      pend     <= '0;
      insrv    <= '0;
      mask     <= '1;
      ie       <= 1'b0;
      sp       <= '0;
      take_idx <= '0;
      take     <= 1'b0;
      ret      <= 1'b0;
      vector   <= VEC_BASE;
      for (int k = 0; k < DEPTH; k++) stack[k] <= '0;
    end else begin
      take <= 1'b0;
      ret  <= 1'b0;

      // A new edge on a line being cleared this cycle keeps it pending
      pend <= (pend & ~((state == TAKE) ? take_onehot : '0)) | rise;

      if (bus.in_cpw) begin
        mask <= bus.in_cpd[NUM_IRQ-1:0];
`ifdef IRQ_NEST_EN
        ie   <= bus.in_cpd[NUM_IRQ];
`else
        // IE stays owned by the take/return sequence while a handler runs
        if (insrv == '0) ie <= bus.in_cpd[NUM_IRQ];
`endif
      end

      case (state)
        RUN: begin
          if (bus.in_eret && (insrv != '0)) begin
            state <= RET;
            ret   <= 1'b1;
          end else if (any_elig) begin
            state    <= TAKE;
            take     <= 1'b1;
            take_idx <= win_idx;
            vector   <= VEC_BASE + VEC_STRIDE * 32'(win_idx);
`ifndef IRQ_NEST_EN
            ie       <= 1'b0;
`endif
          end
        end
        TAKE: begin
          // The squashed instruction's PC is where the handler returns
          for (int k = 0; k < DEPTH; k++) begin
            if (sp == SPW'(k)) stack[k] <= bus.in_pc;
          end
          if (sp != SPW'(DEPTH)) sp <= sp + 1'b1;
          insrv <= insrv | take_onehot;
          state <= GUARD;
        end
        GUARD: begin
          state <= RUN;
        end
        RET: begin
          if (sp != '0) sp <= sp - 1'b1;
          insrv <= insrv & ~insrv_top;
`ifndef IRQ_NEST_EN
          ie    <= 1'b1;
`endif
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.out_take   = take;
  assign bus.out_vector = vector;
  assign bus.out_ret    = ret;
  assign bus.out_epc    = epc;
  assign bus.out_pend   = pend;
  assign bus.out_insrv  = insrv;
  assign bus.out_ie     = ie;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench: stimulus pushes expected take/return events; a negedge monitor pops and compares.
// Level checks (pend, insrv, ie, epc, pulse timing) are made inline one step after each edge.
// Both the nested and non-nested builds are covered via IRQ_NEST_EN.
module tb_irq_sequencer;

`ifdef IRQ_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  irq_sequencer_if #(.NUM_IRQ(3)) bus ();

  irq_sequencer #(.NUM_IRQ(3)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ret;
    logic [31:0] addr;
  } ev_t;

  ev_t q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_take(input logic [31:0] a);
    ev_t e;
    e.is_ret = 1'b0;
    e.addr   = a;
    q.push_back(e);
  endtask

  task automatic push_ret(input logic [31:0] a);
    ev_t e;
    e.is_ret = 1'b1;
    e.addr   = a;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every take/ret pulse must match the next expected event
  always @(negedge clk) begin
    ev_t         e;
    logic [31:0] act;
    if (bus.out_take || bus.out_ret) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: take=%b ret=%b vector=%h epc=%h, none expected",
                 bus.out_take, bus.out_ret, bus.out_vector, bus.out_epc);
      end else begin
        e = q.pop_front();
        if ((bus.out_take == bus.out_ret) || (bus.out_ret != e.is_ret)) begin
          n_chk++;
          n_fail++;
          $display("FAIL event_kind: take=%b ret=%b, expected ret=%b", bus.out_take, bus.out_ret, e.is_ret);
        end else begin
          act = e.is_ret ? bus.out_epc : bus.out_vector;
          chk(e.is_ret ? "ret_epc" : "take_vector", act, e.addr);
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.in_irq  = 3'b001;
    bus.in_pc   = 32'h40;
    bus.in_eret = 1'b0;
    bus.in_cpw  = 1'b0;
    bus.in_cpd  = '0;
    repeat (3) tick();

    // Reset values
    chk("rst_pend",   bus.out_pend, 3'b000);
    chk("rst_insrv",  bus.out_insrv, 3'b000);
    chk("rst_ie",     bus.out_ie, 1'b0);
    chk("rst_take",   bus.out_take, 1'b0);
    chk("rst_ret",    bus.out_ret, 1'b0);
    chk("rst_vector", bus.out_vector, 32'h1000);
    chk("rst_epc",    bus.out_epc, 32'h0);
    rst = 1'b0;
    tick();
    tick();
    chk("held_line_no_pend", bus.out_pend, 3'b000);

    // Enable all lines, then a fresh edge on line 0
    bus.in_cpd = 4'b1111;
    bus.in_cpw = 1'b1;
    tick();
    bus.in_cpw = 1'b0;
    chk("cpw_ie", bus.out_ie, 1'b1);
    bus.in_irq = 3'b000;
    tick();
    bus.in_irq = 3'b001;
    push_take(32'h1000);
    tick();
    chk("t1_no_take_n1", bus.out_take, 1'b0);
    chk("t1_pend", bus.out_pend, 3'b001);
    tick();
    chk("t1_take_n2", bus.out_take, 1'b1);
    tick();
    chk("t1_insrv", bus.out_insrv, 3'b001);
    chk("t1_pend_clr", bus.out_pend, 3'b000);
    chk("t1_epc", bus.out_epc, 32'h40);
    chk("t1_ie", bus.out_ie, NEST);
    tick();
    bus.in_eret = 1'b1;
    push_ret(32'h40);
    tick();
    chk("t1_ret", bus.out_ret, 1'b1);
    bus.in_eret = 1'b0;
    tick();
    chk("t1_insrv_done", bus.out_insrv, 3'b000);
    chk("t1_ie_after", bus.out_ie, 1'b1);

    // Simultaneous rise of lines 0 and 2: line 2 wins
    bus.in_irq = 3'b000;
    tick();
    bus.in_irq = 3'b101;
    push_take(32'h1200);
    tick();
    chk("t2_pend", bus.out_pend, 3'b101);
    tick();
    chk("t2_take", bus.out_take, 1'b1);
    tick();
    chk("t2_epc", bus.out_epc, 32'h40);
    chk("t2_pend_left", bus.out_pend, 3'b001);
    chk("t2_insrv", bus.out_insrv, 3'b100);
    tick();
    tick();
    chk("t4_pend_blocked", bus.out_pend, 3'b001);
    chk("t4_no_take", bus.out_take, 1'b0);

    // ERET releases line 2; line 0 taken on the RUN cycle after RET
    bus.in_pc   = 32'h44;
    bus.in_eret = 1'b1;
    push_ret(32'h40);
    push_take(32'h1000);
    tick();
    chk("t4_ret", bus.out_ret, 1'b1);
    bus.in_eret = 1'b0;
    tick();
    chk("t4_run_insrv", bus.out_insrv, 3'b000);
    chk("t4_run_no_take", bus.out_take, 1'b0);
    tick();
    chk("t4_take", bus.out_take, 1'b1);
    tick();
    chk("t4_epc", bus.out_epc, 32'h44);
    chk("t4_insrv", bus.out_insrv, 3'b001);
    tick();
    bus.in_eret = 1'b1;
    push_ret(32'h44);
    tick();
    bus.in_eret = 1'b0;
    tick();

`ifdef IRQ_NEST_EN
    // Nested: line 2 preempts line 1
    bus.in_irq = 3'b000;
    tick();
    bus.in_pc  = 32'h80;
    bus.in_irq = 3'b010;
    push_take(32'h1100);
    repeat (4) tick();
    bus.in_pc  = 32'h1108;
    bus.in_irq = 3'b110;
    push_take(32'h1200);
    tick();
    tick();
    chk("t3_nested_take", bus.out_take, 1'b1);
    tick();
    chk("t3_insrv", bus.out_insrv, 3'b110);
    chk("t3_epc", bus.out_epc, 32'h1108);
    tick();
    bus.in_eret = 1'b1;
    push_ret(32'h1108);
    tick();
    bus.in_eret = 1'b0;
    tick();
    chk("t3_insrv_inner_done", bus.out_insrv, 3'b010);
    bus.in_eret = 1'b1;
    push_ret(32'h80);
    tick();
    bus.in_eret = 1'b0;
    tick();
    chk("t3_insrv_done", bus.out_insrv, 3'b000);
`else
    // Non-nested: IE cleared by the take blocks line 2 until ERET
    bus.in_irq = 3'b000;
    tick();
    bus.in_pc  = 32'h80;
    bus.in_irq = 3'b001;
    push_take(32'h1000);
    tick();
    tick();
    tick();
    chk("t6_ie_clr", bus.out_ie, 1'b0);
    tick();
    bus.in_irq = 3'b101;
    tick();
    tick();
    tick();
    chk("t6_pend_blocked", bus.out_pend, 3'b100);
    chk("t6_insrv", bus.out_insrv, 3'b001);
    bus.in_eret = 1'b1;
    push_ret(32'h80);
    push_take(32'h1200);
    tick();
    bus.in_eret = 1'b0;
    tick();
    chk("t6_ie_set", bus.out_ie, 1'b1);
    chk("t6_insrv_done", bus.out_insrv, 3'b000);
    tick();
    chk("t6_take", bus.out_take, 1'b1);
    tick();
    chk("t6_ie_clr2", bus.out_ie, 1'b0);
    tick();
    bus.in_eret = 1'b1;
    push_ret(32'h80);
    tick();
    bus.in_eret = 1'b0;
    tick();
    chk("t6_ie_final", bus.out_ie, 1'b1);
`endif

    // ERET and a new eligible request in the same RUN cycle: RET first, then TAKE
    bus.in_irq = 3'b000;
    tick();
    bus.in_pc  = 32'h90;
    bus.in_irq = 3'b001;
    push_take(32'h1000);
    repeat (4) tick();
    bus.in_irq = 3'b011;
    tick();
    bus.in_pc   = 32'h94;
    bus.in_eret = 1'b1;
    push_ret(32'h90);
    push_take(32'h1100);
    tick();
    chk("t5_ret_first", bus.out_ret, 1'b1);
    chk("t5_no_take_yet", bus.out_take, 1'b0);
    bus.in_eret = 1'b0;
    tick();
    tick();
    chk("t5_take_after", bus.out_take, 1'b1);
    tick();
    tick();
    bus.in_eret = 1'b1;
    push_ret(32'h94);
    tick();
    bus.in_eret = 1'b0;
    tick();

    // Reset asserted during TAKE
    bus.in_irq = 3'b111;
    push_take(32'h1200);
    tick();
    tick();
    chk("t5_take_pre_rst", bus.out_take, 1'b1);
    rst = 1'b1;
    tick();
    chk("t5_rst_take",   bus.out_take, 1'b0);
    chk("t5_rst_ret",    bus.out_ret, 1'b0);
    chk("t5_rst_pend",   bus.out_pend, 3'b000);
    chk("t5_rst_insrv",  bus.out_insrv, 3'b000);
    chk("t5_rst_ie",     bus.out_ie, 1'b0);
    chk("t5_rst_vector", bus.out_vector, 32'h1000);
    chk("t5_rst_epc",    bus.out_epc, 32'h0);
    rst = 1'b0;
    tick();
    tick();
    chk("t5_post_rst_pend", bus.out_pend, 3'b000);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
